// File: rtl/ret_stack_pkg.sv
// Shared TB4004 constants and the ret_stack operation decode.
// Build option: RET_STACK_WRAP_EN selects overwrite-oldest on push-while-full.
package tb4004_pkg;
    localparam int ADDR_W          = 12;
    localparam int RET_STACK_DEPTH = 8;
endpackage

package ret_stack_pkg;
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_PUSH_FULL,
        OP_POP,
        OP_POP_EMPTY,
        OP_REPLACE,
        OP_PUSH_UNDER
    } op_e;

    // Push+pop on an empty stack degrades to a plain push plus an underflow mark.
    function automatic op_e decode_op(input logic push, input logic pop,
                                      input logic empty, input logic full);
        op_e op;
        op = OP_IDLE;
        if (push && pop)
            op = empty ? OP_PUSH_UNDER : OP_REPLACE;
        else if (push)
            op = full ? OP_PUSH_FULL : OP_PUSH;
        else if (pop)
            op = empty ? OP_POP_EMPTY : OP_POP;
        return op;
    endfunction
endpackage

// File: rtl/ret_stack_if.sv
// Request/status bundle between the TB4004 sequencer (master) and ret_stack (slave).
interface ret_stack_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pushData;
    logic             clrErr;
    logic [WIDTH-1:0] topData;
    logic [WIDTH-1:0] popData;
    logic             popValid;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, pushData, clrErr,
        input  topData, popData, popValid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, pushData, clrErr,
        output topData, popData, popValid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ret_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module ret_stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // No reset so the array can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ret_stack.sv
// Return-address stack for TB4004: push/pop/replace-top, occupancy status, sticky errors.
// Define RET_STACK_WRAP_EN for 4004-style overwrite of the oldest entry when full.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int WIDTH = tb4004_pkg::ADDR_W,
    parameter int DEPTH = tb4004_pkg::RET_STACK_DEPTH
) (
    input logic       clk,
    input logic       rst,
    ret_stack_if.slave bus
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] ptr, ptr_nxt, top_idx, waddr;
    logic [PTR_W:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] rdata, pop_q;
    logic             pop_vld_q, ovf_q, unf_q;
    logic             we, pop_take, set_ovf, set_unf;
    logic             is_empty, is_full;
    op_e              op;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_FULL);
    assign top_idx  = ptr - 1'b1;

    ret_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we & ~rst),
        .waddr (waddr),
        .wdata (bus.pushData),
        .raddr (top_idx),
        .rdata (rdata)
    );

    always_comb begin
        op       = decode_op(bus.push, bus.pop, is_empty, is_full);
        we       = 1'b0;
        waddr    = ptr;
        ptr_nxt  = ptr;
        cnt_nxt  = cnt;
        pop_take = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (op)
            OP_PUSH, OP_PUSH_UNDER: begin
                we      = 1'b1;
                ptr_nxt = ptr + 1'b1;
                cnt_nxt = cnt + 1'b1;
                set_unf = (op == OP_PUSH_UNDER);
            end
            OP_PUSH_FULL: begin
                set_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
                // Oldest entry sits at ptr when full; overwrite it and keep count pinned.
                we      = 1'b1;
                ptr_nxt = ptr + 1'b1;
`endif
            end
            OP_POP: begin
                pop_take = 1'b1;
                ptr_nxt  = top_idx;
                cnt_nxt  = cnt - 1'b1;
            end
            OP_POP_EMPTY: begin
                set_unf = 1'b1;
            end
            OP_REPLACE: begin
                we       = 1'b1;
                waddr    = top_idx;
                pop_take = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            pop_q     <= '0;
            pop_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            pop_vld_q <= pop_take;
            if (pop_take)
                pop_q <= rdata;
            // A set in the same cycle as clrErr wins.
            ovf_q     <= set_ovf | (ovf_q & ~bus.clrErr);
            unf_q     <= set_unf | (unf_q & ~bus.clrErr);
        end
    end

    assign bus.topData   = is_empty ? '0 : rdata;
    assign bus.popData   = pop_q;
    assign bus.popValid  = pop_vld_q;
    assign bus.count     = cnt;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: doc/ret_stack.md
# ret_stack

Parametrised return-address stack for the TB4004 core. It holds subroutine return addresses pushed by JMS and hands them back on BBL. Each pop produces a registered pop result and a one-cycle `popValid` pulse, which cpuTop ORs into the PC load path. Width, depth, a defined simultaneous push/pop (replace-top) case, occupancy/full/empty status, clearable sticky error flags and an optional 4004-style wrap mode are added over the fixed 8×12 stack.

## Interface
Parameters:
- `WIDTH`, default 12: entry width in bits (PC width).
- `DEPTH`, default 8: number of entries; power of two, ≥2. `PTR_W = $clog2(DEPTH)` is a derived localparam.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push`  in  1  push `pushData` this cycle.
- `pop`  in  1  pop top entry this cycle.
- `pushData`  in  WIDTH  return address to store.
- `clrErr`  in  1  clears `overflow`/`underflow`.
- `topData`  out  WIDTH  combinational current top entry; 0 when empty.
- `popData`  out  WIDTH  registered value removed by the last pop.
- `popValid`  out  1  one-cycle pulse; `popData` valid.
- `count`  out  PTR_W+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count==0` (combinational).
- `full`  out  1  `count==DEPTH` (combinational).
- `overflow`  out  1  sticky; push attempted while full.
- `underflow`  out  1  sticky; pop attempted while empty.

## Operation
- Internal state:
  - `ptr` (PTR_W), the index of the next free slot, modulo DEPTH.
  - `count`.
  - `mem[DEPTH]`.
  - The top entry is `mem[ptr-1]` (mod DEPTH).
- Reset (`rst`=1 at an edge): `ptr`=0, `count`=0, `popData`=0, `popValid`=0, `overflow`=0, `underflow`=0. Memory contents are not reset. `topData` reads 0 because `empty`=1. Reset overrides all other inputs in the same cycle.
- `popValid` defaults to 0 every cycle. It is a pulse, never held.
- Push only:
  - Not full: `mem[ptr]<=pushData`, `ptr++`, `count++`.
  - Full: `overflow<=1`; other behaviour per Configuration.
- Pop only:
  - Not empty: `popData<=mem[ptr-1]`, `popValid<=1`, `ptr--`, `count--`.
  - Empty: `underflow<=1`; `ptr`, `count`, `popData` unchanged; `popValid`=0.
- Push and pop together (replace top, i.e. BBL immediately followed by JMS):
  - Not empty: `popData<=mem[ptr-1]`, `popValid<=1`, `mem[ptr-1]<=pushData`; `ptr` and `count` unchanged; no overflow, even when full.
  - Empty: `underflow<=1` and the push executes as a normal push; `popValid`=0.
- `clrErr`: clears both sticky flags. If a flag is set in the same cycle, the set wins.
- Arithmetic: `ptr` wraps modulo DEPTH; `count` never exceeds DEPTH and never goes below 0.

## Timing
- Every operation completes in one cycle. Results are visible after the sampling edge.
- `topData`, `empty` and `full` reflect the updated state in the cycle after a push or pop.
- `popData` and `popValid` are valid in the cycle after `pop` is sampled. The consumer loads PC in that cycle.
- Back-to-back pops on consecutive cycles give consecutive `popValid` pulses with LIFO data.
- No handshake or back-pressure; every request is accepted or flagged in the same cycle.

## Configuration
- `RET_STACK_WRAP_EN` defined:
  - A push while full writes `mem[ptr]`, advances `ptr`, keeps `count`=DEPTH, and silently overwrites the oldest entry (Intel 4004 behaviour).
  - `overflow` is still set to mark the loss.
- Not defined:
  - A push while full is dropped; `mem`, `ptr` and `count` are unchanged.
  - `overflow` is set.
- Pop, underflow and replace-top behaviour are identical in both builds.

## Structure
- `tb4004_pkg` holds the shared constants: `ADDR_W`=12 and `RET_STACK_DEPTH`=8. These are the defaults used by cpuTop when instantiating.
- Sub-module `ret_stack_mem` is a DEPTH×WIDTH register array:
  - one synchronous write port (`we`, `waddr`, `wdata`);
  - one combinational read port (`raddr`, `rdata`);
  - distributed-RAM friendly, no reset.
- `ret_stack` contains the pointer/count/flag logic and the output registers.

## Test plan
- Reset, then push 0x123, 0x456, 0x789 → `count`=3, `topData`=0x789. Three pops → `popData` 0x789, 0x456, 0x123 with `popValid` one cycle each; then `empty`=1, `topData`=0.
- Pop while empty → `underflow`=1, `count`=0, `popValid`=0. Then `clrErr` → `underflow`=0. `clrErr` together with another empty pop → `underflow` stays 1.
- Fill 8 entries (0x001..0x008), then push 0x0AA:
  - Without `RET_STACK_WRAP_EN`: `overflow`=1, `topData`=0x008, and eight pops return 0x008..0x001.
  - With `RET_STACK_WRAP_EN`: `topData`=0x0AA, and eight pops return 0x0AA, 0x008..0x002.
- With `count`=2 and top 0x200, push 0x300 together with pop → `popData`=0x200, `popValid`=1, `topData`=0x300, `count`=2. When full, the same stimulus gives no `overflow`.
- Push together with pop while empty → `underflow`=1, `count`=1, `topData`=pushData, `popValid`=0.
- Assert `rst` mid-sequence with `count`=5 and `overflow`=1 → next cycle all outputs are at their reset values. Parameter sweep `WIDTH`=8 / `DEPTH`=4 repeats the first scenario.
